// File: rtl/spi_pkg.sv
// Shared SPI master definitions: command opcodes and controller FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CTRL  = 3'd1,
    SHIFT = 3'd2,
    TURN  = 3'd3,
    CAPT  = 3'd4,
    GAP   = 3'd5
  } state_t;

endpackage

// File: rtl/spi_master_shifter.sv
// Datapath for the SPI master: loadable tx frame shifter, rx capture shifter, phase down-counter.
// Latency: tx/rx/counter update on the rising edge after their strobe; rx_next is combinational.
// Backpressure: none; strobes come from the controlling FSM and are obeyed every cycle.
// Ports: clk/rst; load + load_dat (frame {op,data}); shift; capture + miso; cnt_load + cnt_init;
//        tx_msb (next bit to send), rx / rx_next (captured byte, now / after this edge), cnt_zero.
module spi_master_shifter #(
  parameter int ADDR_SIZE = 8,
  parameter int CNT_W     = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [ADDR_SIZE+1:0]   load_dat,
  input  logic                   shift,
  input  logic                   capture,
  input  logic                   miso,
  input  logic                   cnt_load,
  input  logic [CNT_W-1:0]       cnt_init,
  output logic                   tx_msb,
  output logic [ADDR_SIZE-1:0]   rx,
  output logic [ADDR_SIZE-1:0]   rx_next,
  output logic                   cnt_zero
);

  localparam int FRAME_W = ADDR_SIZE + 2;

  logic [FRAME_W-1:0] tx;
  logic [CNT_W-1:0]   cnt;

  assign tx_msb   = tx[FRAME_W-1];
  assign rx_next  = {rx[ADDR_SIZE-2:0], miso};
  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx  <= '0;
      rx  <= '0;
      cnt <= '0;
    end else begin
      if (load)
        tx <= load_dat;
      else if (shift)
        tx <= {tx[FRAME_W-2:0], 1'b0};

      if (capture)
        rx <= rx_next;

      // Reload on phase entry; otherwise count down and park at zero.
      if (cnt_load)
        cnt <= cnt_init;
      else if (!cnt_zero)
        cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Command-driven SPI master: serialises {ctrl,op,data} per SS_n-low frame, captures read-data byte.
// Latency: SS_n falls the cycle after accept; rsp_valid 1+FRAME_W+TURN_CYCLES+ADDR_SIZE cycles after that.
// Backpressure: cmd_ready low from accept until IDLE re-entered; cmd_valid while not ready is dropped.
// Ports: clk/rst; cmd_valid/cmd_ready/cmd_op/cmd_data; rsp_valid/rsp_data; busy; SS_n/MOSI/MISO.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int ADDR_SIZE   = 8,
  parameter int TURN_CYCLES = 2,
  parameter int IDLE_GAP    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [ADDR_SIZE-1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [ADDR_SIZE-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  localparam int FRAME_W = ADDR_SIZE + 2;
  localparam int CNT_W   = $clog2(FRAME_W + TURN_CYCLES + ADDR_SIZE + IDLE_GAP + 1);

  localparam logic [CNT_W-1:0] SHIFT_INIT = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TURN_INIT  = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CAPT_INIT  = CNT_W'(ADDR_SIZE - 1);
  localparam logic [CNT_W-1:0] GAP_INIT   = CNT_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  state_t state, nxt;

  logic                 accept;
  logic                 is_rd;
  logic                 shift, capture, cnt_load, cnt_zero, tx_msb;
  logic [CNT_W-1:0]     cnt_init;
  logic                 mosi_d;
  logic                 rsp_fire;
  logic [ADDR_SIZE-1:0] rx, rx_next;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_fire  = (state == CAPT) && cnt_zero;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt      = state;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_init = '0;
    case (state)
      IDLE:    if (cmd_valid) nxt = CTRL;
      CTRL:    nxt = SHIFT;
      SHIFT:   if (cnt_zero) begin
                 if (is_rd)
                   nxt = (TURN_CYCLES > 0) ? TURN : CAPT;
                 else
                   nxt = (IDLE_GAP > 0) ? GAP : IDLE;
               end
      TURN:    if (cnt_zero) nxt = CAPT;
      CAPT:    begin
                 capture = 1'b1;
                 if (cnt_zero) nxt = (IDLE_GAP > 0) ? GAP : IDLE;
               end
      GAP:     if (cnt_zero) nxt = IDLE;
      default: nxt = IDLE;
    endcase

    // The tx register advances on every edge that lands in SHIFT, including CTRL->SHIFT,
    // so the MOSI register always picks up the current MSB before it moves.
    shift = (nxt == SHIFT);

    if (nxt != state) begin
      cnt_load = 1'b1;
      case (nxt)
        SHIFT:   cnt_init = SHIFT_INIT;
        TURN:    cnt_init = TURN_INIT;
        CAPT:    cnt_init = CAPT_INIT;
        GAP:     cnt_init = GAP_INIT;
        default: cnt_init = '0;
      endcase
    end

    mosi_d = 1'b0;
    if (nxt == CTRL)
      mosi_d = cmd_op[1];
    else if (nxt == SHIFT)
      mosi_d = tx_msb;
  end

  // Outputs are registered from the next-state decode so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      is_rd     <= 1'b0;
    end else begin
      SS_n      <= !(nxt == CTRL || nxt == SHIFT || nxt == TURN || nxt == CAPT);
      MOSI      <= mosi_d;
      busy      <= (nxt != IDLE);
      rsp_valid <= rsp_fire;
      if (rsp_fire)
        rsp_data <= rx_next;
      if (accept)
        is_rd <= (cmd_op == OP_RD_DATA);
    end
  end

  spi_master_shifter #(
    .ADDR_SIZE (ADDR_SIZE),
    .CNT_W     (CNT_W)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_dat ({cmd_op, cmd_data}),
    .shift    (shift),
    .capture  (capture),
    .miso     (MISO),
    .cnt_load (cnt_load),
    .cnt_init (cnt_init),
    .tx_msb   (tx_msb),
    .rx       (rx),
    .rx_next  (rx_next),
    .cnt_zero (cnt_zero)
  );

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural RAM-backed SPI slave.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_master_ctrl;

  localparam int AS = 8;
  localparam int TC = 2;
  localparam int IG = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_ready, rsp_valid, busy, SS_n, MOSI, MISO;
  logic [7:0] rsp_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.ADDR_SIZE(AS), .TURN_CYCLES(TC), .IDLE_GAP(IG)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  // Behavioural slave: ctrl bit + 10 frame bits sampled on rising edges while SS_n is low,
  // read data driven MSB first once the turnaround window has elapsed.
  logic [7:0]  mem [256];
  logic [7:0]  wa, ra, rd_byte;
  logic [10:0] sl_sr;
  logic [9:0]  sl_frame;
  int          sl_cnt;
  logic        sl_rd;

  assign sl_frame = {sl_sr[8:0], MOSI};

  always @(posedge clk) begin
    if (SS_n) begin
      sl_cnt <= 0;
      sl_rd  <= 1'b0;
    end else begin
      sl_cnt <= sl_cnt + 1;
      sl_sr  <= {sl_sr[9:0], MOSI};
      if (sl_cnt == 10) begin
        case (sl_frame[9:8])
          2'b00: wa <= sl_frame[7:0];
          2'b01: mem[wa] <= sl_frame[7:0];
          2'b10: ra <= sl_frame[7:0];
          default: begin
            sl_rd   <= 1'b1;
            rd_byte <= mem[ra];
          end
        endcase
      end
    end
  end

  always_comb begin
    MISO = 1'b0;
    if (sl_rd && sl_cnt >= 11 + TC && sl_cnt < 11 + TC + AS)
      MISO = rd_byte[3'(AS - 1 + 11 + TC - sl_cnt)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    bit rdy;
    rdy = 1'b0;
    for (int c = 0; c < 50 && !rdy; c++) begin
      @(negedge clk);
      rdy = cmd_ready;
    end
    chk("issue_ready", 32'(rdy), 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
  endtask

  // Observes one frame plus its gap, returning at the first negedge with cmd_ready high.
  // In toggle mode cmd_* are scrambled while SS_n is low and then the hold command is presented.
  task automatic collect(input bit toggle, input logic [1:0] hop, input logic [7:0] hdat,
                         output logic [31:0] bits, output int nlow, output int nrsp,
                         output int ngap, output int nbusy, output logic [7:0] rlast);
    bit done;
    done = 1'b0;
    bits = '0; nlow = 0; nrsp = 0; ngap = 0; nbusy = 0; rlast = '0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (!SS_n) begin
        bits = {bits[30:0], MOSI};
        nlow++;
      end else if (!cmd_ready) begin
        ngap++;
      end
      if (busy) nbusy++;
      if (rsp_valid) begin
        nrsp++;
        rlast = rsp_data;
      end
      if (cmd_ready) done = 1'b1;
      if (toggle && !SS_n) begin
        cmd_valid = ~cmd_valid;
        cmd_op    = 2'($urandom);
        cmd_data  = 8'($urandom);
      end else if (toggle) begin
        cmd_valid = 1'b1;
        cmd_op    = hop;
        cmd_data  = hdat;
      end else begin
        cmd_valid = 1'b0;
      end
    end
    chk("frame_done", 32'(done), 1);
  endtask

  logic [31:0] bits;
  int          nlow, nrsp, ngap, nbusy;
  logic [7:0]  rlast;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", 32'(SS_n), 1);
    chk("rst_mosi", 32'(MOSI), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    rst = 1'b0;

    // wr-addr 0xFA
    issue(2'b00, 8'hFA);
    collect(1'b0, 2'b00, 8'h00, bits, nlow, nrsp, ngap, nbusy, rlast);
    chk("wa_low", 32'(nlow), 11);
    chk("wa_bits", bits & 32'h7FF, 32'h0FA);
    chk("wa_gap", 32'(ngap), 2);
    chk("wa_busy", 32'(nbusy), 13);
    chk("wa_rsp", 32'(nrsp), 0);

    // wr-data 0x8F
    issue(2'b01, 8'h8F);
    collect(1'b0, 2'b00, 8'h00, bits, nlow, nrsp, ngap, nbusy, rlast);
    chk("wd_low", 32'(nlow), 11);
    chk("wd_bits", bits & 32'h7FF, 32'h18F);
    chk("wd_ram250", 32'(mem[250]), 32'h8F);

    // rd-addr 0xFA, then rd-data
    issue(2'b10, 8'hFA);
    collect(1'b0, 2'b00, 8'h00, bits, nlow, nrsp, ngap, nbusy, rlast);
    chk("ra_low", 32'(nlow), 11);
    chk("ra_bits", bits & 32'h7FF, 32'h6FA);
    issue(2'b11, 8'h00);
    collect(1'b0, 2'b00, 8'h00, bits, nlow, nrsp, ngap, nbusy, rlast);
    chk("rd_low", 32'(nlow), 21);
    chk("rd_bits", bits & 32'h1FFFFF, 32'h1C0000);
    chk("rd_gap", 32'(ngap), 2);
    chk("rd_busy", 32'(nbusy), 23);
    chk("rd_rsp_cnt", 32'(nrsp), 1);
    chk("rd_rsp_data", 32'(rlast), 32'h8F);
    chk("rd_rsp_hold", 32'(rsp_data), 32'h8F);

    // Reset during bit 5 of a rd-data SHIFT phase
    issue(2'b11, 8'h00);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("ab_ss_low", 32'(SS_n), 0);
    chk("ab_mosi_bit5", 32'(MOSI), 0);
    chk("ab_rsp_before", 32'(rsp_data), 32'h8F);
    rst = 1'b1;
    #1;
    chk("ab_ss_n", 32'(SS_n), 1);
    chk("ab_mosi", 32'(MOSI), 0);
    chk("ab_rsp_data", 32'(rsp_data), 0);
    chk("ab_rsp_valid", 32'(rsp_valid), 0);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    issue(2'b00, 8'h3C);
    collect(1'b0, 2'b00, 8'h00, bits, nlow, nrsp, ngap, nbusy, rlast);
    chk("ab_next_low", 32'(nlow), 11);
    chk("ab_next_bits", bits & 32'h7FF, 32'h03C);
    chk("ab_next_rsp", 32'(nrsp), 0);
    chk("ab_ram250", 32'(mem[250]), 32'h8F);

    // Scrambled cmd_* during a frame, then a continuously held command
    issue(2'b01, 8'h5A);
    collect(1'b1, 2'b00, 8'h11, bits, nlow, nrsp, ngap, nbusy, rlast);
    chk("tg_low", 32'(nlow), 11);
    chk("tg_bits", bits & 32'h7FF, 32'h15A);
    chk("tg_gap", 32'(ngap), 2);
    chk("tg_ram5a_addr", 32'(mem[8'h3C]), 32'h5A);
    collect(1'b0, 2'b00, 8'h00, bits, nlow, nrsp, ngap, nbusy, rlast);
    chk("hold_low", 32'(nlow), 11);
    chk("hold_bits", bits & 32'h7FF, 32'h011);
    chk("hold_gap", 32'(ngap), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
